boss_sched: RTL and testbench

Game-phase scheduler for the typing game. It sequences the player through normal play and timed boss rounds, owns the shared 1-of-N tick prescaler, and issues the `boss` and `start` controls. It also issues the `pause` status consumed by the display and input blocks. It sits between the keystroke checker, which produces hit pulses, and the display/scoring logic.

---
 rtl/boss_sched_pkg.sv | 27 ++
 rtl/boss_sched_if.sv | 37 +++
 rtl/boss_sched_tick_gen.sv | 38 +++
 rtl/boss_sched.sv | 175 +++++++++++++++++
 tb/tb_boss_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boss_sched_pkg.sv
// boss_sched shared types and defaults.
// Phase encoding, default parameters and a counter-width helper.
package boss_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        BOSS = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } phase_e;

    localparam int DEF_TICK_DIV   = 2500000;
    localparam int DEF_BOSS_TICKS = 10;
    localparam int DEF_HIT_GOAL   = 8;
    localparam int DEF_NUM_BOSS   = 3;

    localparam int BOSS_W  = 5;
    localparam int TL_W    = 6;
    localparam int PHASE_W = 3;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boss_sched_if.sv
// boss_sched control/status bundle.
// pause_btn exists only with BOSS_SCHED_USER_PAUSE_EN defined.
interface boss_sched_if;

    logic       start_btn;
    logic       hit;
`ifdef BOSS_SCHED_USER_PAUSE_EN
    logic       pause_btn;
`endif
    logic [4:0] boss;
    logic       start;
    logic       pause;
    logic       tick;
    logic [5:0] time_left;
    logic [2:0] phase;
    logic       win;
    logic       lose;

    modport master (
`ifdef BOSS_SCHED_USER_PAUSE_EN
        output pause_btn,
`endif
        output start_btn, hit,
        input  boss, start, pause, tick,
        input  time_left, phase, win, lose
    );

    modport slave (
`ifdef BOSS_SCHED_USER_PAUSE_EN
        input  pause_btn,
`endif
        input  start_btn, hit,
        output boss, start, pause, tick,
        output time_left, phase, win, lose
    );

endinterface

// File: rtl/boss_sched_tick_gen.sv
// tick_gen: 1-of-DIV prescaler with enable and clear.
// tick is high while enabled in the last count of the period.
module tick_gen
    import boss_sched_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over count; wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/boss_sched.sv
// boss_sched: typing-game phase scheduler (play / boss rounds).
// Optional BOSS_SCHED_USER_PAUSE_EN adds a user pause button.
module boss_sched
    import boss_sched_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int BOSS_TICKS = DEF_BOSS_TICKS,
    parameter int HIT_GOAL   = DEF_HIT_GOAL,
    parameter int NUM_BOSS   = DEF_NUM_BOSS
) (
    input logic         clk,
    input logic         rst_n,
    boss_sched_if.slave bus
);

    localparam int HCW = cnt_w(HIT_GOAL + 1);
    localparam logic [HCW-1:0]    GOAL      = HCW'(HIT_GOAL);
    localparam logic [TL_W-1:0]   TL_INIT   = TL_W'(BOSS_TICKS);
    localparam logic [BOSS_W-1:0] LAST_BOSS = BOSS_W'(NUM_BOSS);

    if (NUM_BOSS < 1 || NUM_BOSS > 31 ||
        BOSS_TICKS < 1 || BOSS_TICKS > 63) begin : g_cfg_check
        $error("boss_sched: need NUM_BOSS 1..31, BOSS_TICKS 1..63");
    end

    phase_e            phase_q, phase_d;
    logic [BOSS_W-1:0] boss_q, boss_d;
    logic [TL_W-1:0]   tl_q, tl_d;
    logic [HCW-1:0]    hits_q, hits_d, hits_inc;
    logic              start_btn_q, start_rise_q, start_rise_d;
    logic              running, frozen, hit_ok, goal;
    logic              boss_entry, tick_w;

`ifdef BOSS_SCHED_USER_PAUSE_EN
    logic pause_btn_q, pause_rise_q, pause_rise_d;
    logic upause_q, upause_d;

    // Pause button rise detect and user-pause toggle.
    always_comb begin
        pause_rise_d = bus.pause_btn & ~pause_btn_q;
        upause_d     = upause_q ^ (running & pause_rise_q);
        if (phase_d == IDLE) upause_d = 1'b0;
    end

    // Pause button edge registers and user-pause flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_btn_q  <= 1'b0;
            pause_rise_q <= 1'b0;
            upause_q     <= 1'b0;
        end else begin
            pause_btn_q  <= bus.pause_btn;
            pause_rise_q <= pause_rise_d;
            upause_q     <= upause_d;
        end
    end

    assign frozen = upause_q;
`else
    assign frozen = 1'b0;
`endif

    // Start button rise detect; the pulse is registered.
    always_comb begin
        start_rise_d = bus.start_btn & ~start_btn_q;
    end

    // Start button edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_btn_q  <= 1'b0;
            start_rise_q <= 1'b0;
        end else begin
            start_btn_q  <= bus.start_btn;
            start_rise_q <= start_rise_d;
        end
    end

    // Gameplay qualifiers shared by the FSM and the prescaler.
    always_comb begin
        running  = (phase_q == PLAY) || (phase_q == BOSS);
        hit_ok   = bus.hit & running & ~frozen;
        hits_inc = hits_q + HCW'(1);
        goal     = hit_ok && (hits_inc == GOAL);
    end

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (running & ~frozen),
        .clr   (~running | boss_entry),
        .tick  (tick_w)
    );

    // Next phase and counters; a goal hit beats a same-cycle tick.
    always_comb begin
        phase_d    = phase_q;
        boss_d     = boss_q;
        tl_d       = tl_q;
        hits_d     = hits_q;
        boss_entry = 1'b0;
        unique case (phase_q)
            IDLE: begin
                if (start_rise_q) begin
                    phase_d = PLAY;
                    boss_d  = '0;
                    hits_d  = '0;
                end
            end
            PLAY: begin
                if (goal) begin
                    phase_d    = BOSS;
                    boss_d     = boss_q + BOSS_W'(1);
                    hits_d     = '0;
                    tl_d       = TL_INIT;
                    boss_entry = 1'b1;
                end else if (hit_ok) begin
                    hits_d = hits_inc;
                end
            end
            BOSS: begin
                if (goal) begin
                    if (boss_q == LAST_BOSS) begin
                        phase_d = WIN;
                        hits_d  = hits_inc;
                    end else begin
                        phase_d = PLAY;
                        hits_d  = '0;
                    end
                end else begin
                    if (hit_ok) hits_d = hits_inc;
                    if (tick_w) begin
                        if (tl_q <= TL_W'(1)) begin
                            tl_d    = '0;
                            phase_d = LOSE;
                        end else begin
                            tl_d = tl_q - TL_W'(1);
                        end
                    end
                end
            end
            WIN, LOSE: begin
                if (start_rise_q) phase_d = IDLE;
            end
            default: phase_d = IDLE;
        endcase
    end

    // Phase and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE;
            boss_q  <= '0;
            tl_q    <= '0;
            hits_q  <= '0;
        end else begin
            phase_q <= phase_d;
            boss_q  <= boss_d;
            tl_q    <= tl_d;
            hits_q  <= hits_d;
        end
    end

    assign bus.boss      = boss_q;
    assign bus.time_left = tl_q;
    assign bus.phase     = phase_q;
    assign bus.tick      = tick_w;
    assign bus.pause     = ~running | frozen;
    assign bus.start     = running & ~frozen;
    assign bus.win       = (phase_q == WIN);
    assign bus.lose      = (phase_q == LOSE);

endmodule

// File: tb/tb_boss_sched.sv
// Self-checking bench for boss_sched (small game parameters).
// Directed scenarios plus random play against a rule-level model.
module tb_boss_sched;
    import boss_sched_pkg::*;

    localparam int TD = 4;
    localparam int BT = 3;
    localparam int HG = 2;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    boss_sched_if bus();

    boss_sched #(
        .TICK_DIV   (TD),
        .BOSS_TICKS (BT),
        .HIT_GOAL   (HG),
        .NUM_BOSS   (NB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Rule-level game model, state as seen after each clock edge.
    phase_e m_ph;
    int     m_boss, m_hits, m_tl, m_age;
    bit     m_up;
    bit     s1, s2, p1, p2;

    function automatic void model_reset();
        m_ph = IDLE; m_boss = 0; m_hits = 0; m_tl = 0;
        m_age = 0; m_up = 0; s1 = 0; s2 = 0; p1 = 0; p2 = 0;
    endfunction

    task automatic model_edge();
        bit run, ev_s, ev_p, tk, hv, clr;
        phase_e nph;
        ev_s = s1 && !s2; s2 = s1; s1 = bus.start_btn;
`ifdef BOSS_SCHED_USER_PAUSE_EN
        ev_p = p1 && !p2; p2 = p1; p1 = bus.pause_btn;
`else
        ev_p = 0;
`endif
        run = (m_ph == PLAY) || (m_ph == BOSS);
        tk  = run && !m_up && (m_age % TD == TD - 1);
        hv  = bus.hit && run && !m_up;
        clr = !run;
        nph = m_ph;
        case (m_ph)
            IDLE: if (ev_s) begin
                nph = PLAY; m_boss = 0; m_hits = 0;
            end
            PLAY: if (hv) begin
                m_hits++;
                if (m_hits == HG) begin
                    nph = BOSS; m_boss++; m_hits = 0;
                    m_tl = BT; clr = 1;
                end
            end
            BOSS: begin
                if (hv && m_hits + 1 == HG) begin
                    if (m_boss == NB) begin
                        nph = WIN; m_hits++;
                    end else begin
                        nph = PLAY; m_hits = 0;
                    end
                end else begin
                    if (hv) m_hits++;
                    if (tk) begin
                        m_tl--;
                        if (m_tl == 0) nph = LOSE;
                    end
                end
            end
            default: if (ev_s) nph = IDLE;
        endcase
        if (clr) m_age = 0;
        else if (!m_up) m_age++;
        if (run && ev_p) m_up = !m_up;
        if (nph == IDLE) m_up = 0;
        m_ph = nph;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        bus.start_btn = 1'b0;
        step();
        bus.start_btn = 1'b1;
        step();
        step();
        bus.start_btn = 1'b0;
    endtask

    task automatic hits2();
        bus.hit = 1'b1;
        step();
        step();
        bus.hit = 1'b0;
    endtask

    function automatic logic [17:0] obs_s();
        return {bus.phase, bus.boss, bus.time_left,
                bus.pause, bus.start, bus.win, bus.lose};
    endfunction

    function automatic logic [17:0] exp_s(phase_e p, int b, int tl);
        bit pz;
        pz = !(p == PLAY || p == BOSS);
        return {p, 5'(b), 6'(tl), pz, !pz, p == WIN, p == LOSE};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({obs_s(), bus.tick} !== {exp_s(IDLE, 0, 0), 1'b0}) begin
            errors++;
            $display("FAIL reset got=%h exp=%h",
                     {obs_s(), bus.tick}, {exp_s(IDLE, 0, 0), 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        press();
        checks++;
        if (obs_s() !== exp_s(PLAY, 0, 0)) begin
            errors++;
            $display("FAIL start got=%h exp=%h", obs_s(), exp_s(PLAY, 0, 0));
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.tick !== (i % TD == TD - 1)) begin
                errors++;
                $display("FAIL tick_%0d got=%b exp=%b",
                         i, bus.tick, (i % TD == TD - 1));
            end
            step();
        end
    endtask

    task automatic test_full_win();
        hits2();
        checks++;
        if (obs_s() !== exp_s(BOSS, 1, 3)) begin
            errors++;
            $display("FAIL win_boss1 got=%h exp=%h", obs_s(), exp_s(BOSS, 1, 3));
        end
        hits2();
        checks++;
        if (obs_s() !== exp_s(PLAY, 1, 3)) begin
            errors++;
            $display("FAIL win_play got=%h exp=%h", obs_s(), exp_s(PLAY, 1, 3));
        end
        hits2();
        checks++;
        if (obs_s() !== exp_s(BOSS, 2, 3)) begin
            errors++;
            $display("FAIL win_boss2 got=%h exp=%h", obs_s(), exp_s(BOSS, 2, 3));
        end
        hits2();
        checks++;
        if (obs_s() !== exp_s(WIN, 2, 3)) begin
            errors++;
            $display("FAIL win_win got=%h exp=%h", obs_s(), exp_s(WIN, 2, 3));
        end
        press();
        checks++;
        if (obs_s() !== exp_s(IDLE, 2, 3)) begin
            errors++;
            $display("FAIL win_idle got=%h exp=%h", obs_s(), exp_s(IDLE, 2, 3));
        end
        press();
        checks++;
        if ({bus.phase, bus.boss} !== {PLAY, 5'd0}) begin
            errors++;
            $display("FAIL restart got=%h exp=%h",
                     {bus.phase, bus.boss}, {PLAY, 5'd0});
        end
    endtask

    task automatic test_timeout();
        hits2();
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (obs_s() !== exp_s(i == 12 ? LOSE : BOSS, 1, 3 - i / TD)) begin
                errors++;
                $display("FAIL timeout_%0d got=%h exp=%h", i, obs_s(),
                         exp_s(i == 12 ? LOSE : BOSS, 1, 3 - i / TD));
            end
        end
    endtask

    task automatic test_race();
        press();
        press();
        hits2();
        repeat (10) step();
        hits2();
        checks++;
        if (obs_s() !== exp_s(PLAY, 1, 1)) begin
            errors++;
            $display("FAIL race_play got=%h exp=%h", obs_s(), exp_s(PLAY, 1, 1));
        end
        hits2();
        checks++;
        if (obs_s() !== exp_s(BOSS, 2, 3)) begin
            errors++;
            $display("FAIL race_boss2 got=%h exp=%h", obs_s(), exp_s(BOSS, 2, 3));
        end
        repeat (10) step();
        hits2();
        checks++;
        if (obs_s() !== exp_s(WIN, 2, 1)) begin
            errors++;
            $display("FAIL race_win got=%h exp=%h", obs_s(), exp_s(WIN, 2, 1));
        end
    endtask

`ifdef BOSS_SCHED_USER_PAUSE_EN
    task automatic test_user_pause();
        press();
        press();
        hits2();
        bus.pause_btn = 1'b1;
        step();
        step();
        checks++;
        if ({bus.phase, bus.time_left, bus.pause, bus.start}
            !== {BOSS, 6'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL upause_on got=%h exp=%h",
                     {bus.phase, bus.time_left, bus.pause, bus.start},
                     {BOSS, 6'd3, 1'b1, 1'b0});
        end
        for (int i = 0; i < 20; i++) begin
            bus.hit = (i == 5);
            step();
            checks++;
            if ({bus.phase, bus.time_left, bus.tick, bus.pause}
                !== {BOSS, 6'd3, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL upause_frz_%0d got=%h exp=%h", i,
                         {bus.phase, bus.time_left, bus.tick, bus.pause},
                         {BOSS, 6'd3, 1'b0, 1'b1});
            end
        end
        bus.hit = 1'b0;
        bus.pause_btn = 1'b0;
        step();
        bus.pause_btn = 1'b1;
        step();
        step();
        step();
        checks++;
        if ({bus.time_left, bus.tick, bus.start} !== {6'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL upause_res got=%h exp=%h",
                     {bus.time_left, bus.tick, bus.start}, {6'd3, 1'b1, 1'b1});
        end
        step();
        checks++;
        if (bus.time_left !== 6'd2) begin
            errors++;
            $display("FAIL upause_dec got=%0d exp=2", bus.time_left);
        end
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        checks++;
        if (bus.phase !== BOSS) begin
            errors++;
            $display("FAIL upause_hit got=%0d exp=%0d", bus.phase, BOSS);
        end
        bus.pause_btn = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        logic [18:0] got, exp;
        bit run, pz, tk;
        int hp;
        for (int i = 0; i < 800; i++) begin
            hp = ((i / 100) % 2 == 1) ? 45 : 6;
            bus.hit = ($urandom_range(99) < hp);
            if ($urandom_range(99) < 10) bus.start_btn = ~bus.start_btn;
`ifdef BOSS_SCHED_USER_PAUSE_EN
            if ($urandom_range(99) < 4) bus.pause_btn = ~bus.pause_btn;
`endif
            step();
            run = (m_ph == PLAY) || (m_ph == BOSS);
            pz  = !run || m_up;
            tk  = run && !m_up && (m_age % TD == TD - 1);
            exp = {m_ph, 5'(m_boss), 6'(m_tl), tk, pz, !pz,
                   m_ph == WIN, m_ph == LOSE};
            got = {bus.phase, bus.boss, bus.time_left, bus.tick,
                   bus.pause, bus.start, bus.win, bus.lose};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_%0d got=%h exp=%h", i, got, exp);
            end
        end
        bus.hit = 1'b0;
        bus.start_btn = 1'b0;
`ifdef BOSS_SCHED_USER_PAUSE_EN
        bus.pause_btn = 1'b0;
`endif
        step();
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        press();
        hits2();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_s(), bus.tick} !== {exp_s(IDLE, 0, 0), 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h",
                     {obs_s(), bus.tick}, {exp_s(IDLE, 0, 0), 1'b0});
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        step();
        checks++;
        if (obs_s() !== exp_s(IDLE, 0, 0)) begin
            errors++;
            $display("FAIL reset_rel got=%h exp=%h", obs_s(), exp_s(IDLE, 0, 0));
        end
    endtask

    initial begin
        bus.start_btn = 1'b0;
        bus.hit       = 1'b0;
`ifdef BOSS_SCHED_USER_PAUSE_EN
        bus.pause_btn = 1'b0;
`endif
        test_reset();
        test_start();
        test_full_win();
        test_timeout();
        test_race();
`ifdef BOSS_SCHED_USER_PAUSE_EN
        test_user_pause();
`endif
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
